multicycle_ctrl: RTL

- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute and writeback over the shared ALU, memory port and immediate extender.
- Drives the 2-bit immediate-select bus, ALU mux selects, ALU operation and all datapath write enables.
- Adds memory wait states and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core, with memory wait states and a retired-instruction counter.
// Optional jal support is compiled in when MULTICYCLE_CTRL_JAL_EN is defined.
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [2:0]          alu_control,
    output logic                illegal_instr,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [2:0] funct_alu;
    logic       retire_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:       state_next = S_JAL;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL:      state_next = S_ALUWB;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    // funct3 values outside the supported set quietly fall back to add.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_src       = 2'b00;
        alu_control   = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_R, OP_I: imm_src = 2'b00;
                    OP_SW:             imm_src = 2'b01;
                    OP_BEQ:            imm_src = 2'b10;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:            imm_src = 2'b11;
`endif
                    default:           illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = zero;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
`endif
            default: ;
        endcase
        // The state register is already FETCH during reset, but enables must not leak through mem_ready.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign retire_evt = (state_reg == S_MEMWB) ||
                        (state_reg == S_MEMWRITE && mem_ready) ||
                        (state_reg == S_ALUWB) ||
                        (state_reg == S_BEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retire_count <= '0;
        else if (retire_evt)
            retire_count <= retire_count + RETIRE_W'(1);
    end

endmodule
